game_ctrl: RTL and testbench
============================

# game_ctrl

Game-flow controller for the snake datapath. It owns the game state machine (menu, countdown, run, pause, game over) and replaces the free-running step divider with a scheduled, handshaked step sequence. Each step issues one move request, waits for completion, then issues one point-generation request. It also tracks score and speeds the game up as points are eaten, and exports the mode consumed by `draw` and `generate_point`.

## Interface
- `TICK_INIT`, 7_500_000: clock cycles per game step at game start (10 Hz at 75 MHz).
- `TICK_MIN`, 2_500_000: lower bound on cycles per step.
- `TICK_STEP`, 250_000: period reduction per point eaten.
- `COUNTDOWN_TICKS`, 3: countdown steps before play begins; must be ≥1.
- `WAIT_TO`, 1024: maximum cycles to wait for `move_done` or `gen_done`.
- `SCORE_W`, 8: score width.
- `clk` in 1: the single system clock (75 MHz pixel clock domain).
- `rst` in 1: asynchronous, active-low reset.
- `left` in 1: left mouse button level, synchronous to `clk`.
- `right` in 1: right mouse button level, synchronous to `clk`.
- `move_done` in 1: move unit finished the requested step.
- `collision` in 1: move result flag; valid in the cycle `move_done`=1.
- `gen_done` in 1: point generator finished.
- `ate_point` in 1: point-eaten flag; valid in the cycle `gen_done`=1.
- `move_step` out 1: one-cycle move request.
- `gen_step` out 1: one-cycle point-generation request.
- `snake_clr` out 1: one-cycle clear of snake/map state at game start.
- `mode` out 2: 0 MENU, 1 GAME, 2 PAUSE, 3 OVER.
- `countdown` out 2: remaining countdown steps; saturated display value.
- `score` out SCORE_W: points this game.

## Operation
- Edge detect: `left` and `right` are each registered once. An edge is `cur & ~prev`. Only rising edges are used.
- Tick counter: width is clog2(TICK_INIT+1). It counts 0..period-1. Expiry is the cycle where it equals period-1, and the counter wraps to 0 on expiry.
- States:
  - IDLE: mode=0. On a `left` edge, go to CLEAR.
  - CLEAR: lasts one cycle. `snake_clr`=1, score←0, period←TICK_INIT, countdown←COUNTDOWN_TICKS, counter←0. Go to COUNT.
  - COUNT: mode=1. On each expiry, countdown decrements. On the expiry where countdown=1, countdown←0, counter←0, and go to RUN.
  - RUN: mode=1. Counter runs. On expiry, go to MOVE and assert `move_step`. On a `right` edge, go to PAUSE; the counter holds its value. A `right` edge takes priority over a same-cycle expiry. `left` is ignored.
  - MOVE: wait for `move_done`. If `collision`=1, go to OVER. Otherwise go to GEN and assert `gen_step`.
  - GEN: wait for `gen_done`. If `ate_point`=1, score saturates at 2^SCORE_W-1. Period update: if period < TICK_MIN+TICK_STEP then period←TICK_MIN, else period←period-TICK_STEP. In both cases go to RUN with counter←0.
  - PAUSE: mode=2. Counter is frozen. On a `right` edge, return to RUN and resume from the held count. `left` is ignored.
  - OVER: mode=3. Score is held. On a `left` edge, go to IDLE; score is held until the next CLEAR.
- Timeout: a wait counter is cleared on entry to MOVE and GEN. If it reaches WAIT_TO-1 with no done, go to OVER.
- Done pulses arriving in any state other than the matching wait state are ignored.
- Simultaneous `left` and `right` edges: IDLE starts the game, RUN pauses, PAUSE resumes.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE. All outputs 0: `mode`=0, `score`=0, `countdown`=0, and every pulse output low. Period←TICK_INIT. All counters←0. Reset mid-step abandons the handshake with no further pulses.
- All outputs are registered.
- A `left` or `right` edge changes state at the clock edge where the input is first sampled high, so the new `mode` appears 1 cycle after the input rises.
- `snake_clr` is high for the single cycle after the start edge is sampled.
- `move_step` is high for the single cycle after counter expiry.
- `move_done` is accepted from the cycle after `move_step`, not in the same cycle. The same rule applies to `gen_done` relative to `gen_step`.
- `gen_step` is high in the cycle after the accepted `move_done`.
- `score` and period update in the cycle after `gen_done`.
- Step-to-step interval: period + (move latency) + (gen latency) + 2 cycles.

## Test plan
Use TICK_INIT=10, TICK_MIN=4, TICK_STEP=3, COUNTDOWN_TICKS=2, WAIT_TO=8, SCORE_W=2. Responders answer done 2 cycles after each request.
- Reset: hold `rst`=0 for 5 cycles, then release → mode=0, score=0, countdown=0, no pulses for 50 cycles.
- Start: pulse `left`.
  - `snake_clr` is high for 1 cycle.
  - countdown goes 2→1 after 10 cycles, then →0 after 10 more.
  - The first `move_step` comes 10 cycles after that.
- Speed-up: set `ate_point`=1 on three consecutive steps.
  - score goes 1,2,3, then stays 3 after a fourth.
  - Period goes 7, 4, 4; verify the `move_step` spacing matches.
- Collision: `collision`=1 with `move_done` → mode=3 next cycle, no `gen_step`, score held. A `left` edge then gives mode=0.
- Pause: a `right` edge at count 5 → mode=2 and no `move_step` for 100 cycles. A second `right` edge gives `move_step` exactly 5 cycles after resume.
- Timeout: withhold `move_done` → mode=3 after 8 cycles. A late `move_done` in OVER causes no `gen_step`.

Source files
------------

// File: rtl/game_ctrl.sv
// Game-flow controller for the snake datapath: menu/countdown/run/pause/over FSM,
// handshaked move -> point-generation step sequence, score and speed-up tracking.
module game_ctrl #(
  parameter int TICK_INIT       = 7_500_000,
  parameter int TICK_MIN        = 2_500_000,
  parameter int TICK_STEP       = 250_000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int WAIT_TO         = 1024,
  parameter int SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               left,
  input  logic               right,
  input  logic               move_done,
  input  logic               collision,
  input  logic               gen_done,
  input  logic               ate_point,
  output logic               move_step,
  output logic               gen_step,
  output logic               snake_clr,
  output logic [1:0]         mode,
  output logic [1:0]         countdown,
  output logic [SCORE_W-1:0] score
);

  localparam int CNT_W = $clog2(TICK_INIT + 1);
  localparam int CD_W  = (COUNTDOWN_TICKS < 2) ? 1 : $clog2(COUNTDOWN_TICKS + 1);
  localparam int WT_W  = (WAIT_TO < 2) ? 1 : $clog2(WAIT_TO);

  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(TICK_INIT);
  localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(TICK_MIN);
  localparam logic [CNT_W-1:0] PERIOD_STEP = CNT_W'(TICK_STEP);
  localparam logic [CD_W-1:0]  CD_INIT     = CD_W'(COUNTDOWN_TICKS);
  localparam logic [WT_W-1:0]  WAIT_LAST   = WT_W'(WAIT_TO - 1);

  localparam logic [1:0] MODE_MENU  = 2'd0;
  localparam logic [1:0] MODE_GAME  = 2'd1;
  localparam logic [1:0] MODE_PAUSE = 2'd2;
  localparam logic [1:0] MODE_OVER  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COUNT,
    ST_RUN,
    ST_MOVE,
    ST_GEN,
    ST_PAUSE,
    ST_OVER
  } state_t;

  state_t             state_reg, state_next;
  logic               left_prev_reg, right_prev_reg;
  logic [CNT_W-1:0]   tick_reg, tick_next;
  logic [CNT_W-1:0]   period_reg, period_next;
  logic [CD_W-1:0]    cd_reg, cd_next;
  logic [WT_W-1:0]    wait_reg, wait_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic               move_step_reg, move_step_next;
  logic               gen_step_reg, gen_step_next;
  logic               snake_clr_reg, snake_clr_next;
  logic [1:0]         mode_reg, mode_next;
  logic [1:0]         countdown_reg, countdown_next;

  logic left_edge, right_edge, tick_expired, wait_expired;

  assign left_edge    = left & ~left_prev_reg;
  assign right_edge   = right & ~right_prev_reg;
  assign tick_expired = (tick_reg == period_reg - CNT_W'(1));
  assign wait_expired = (wait_reg == WAIT_LAST);

  // The internal countdown may be wider than the 2-bit display; clamp it at 3.
  generate
    if (CD_W > 2) begin : g_cd_sat
      assign countdown_next = (cd_next > CD_W'(3)) ? 2'd3 : cd_next[1:0];
    end else begin : g_cd_pass
      assign countdown_next = 2'(cd_next);
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    tick_next      = tick_reg;
    period_next    = period_reg;
    cd_next        = cd_reg;
    wait_next      = wait_reg;
    score_next     = score_reg;
    move_step_next = 1'b0;
    gen_step_next  = 1'b0;
    snake_clr_next = 1'b0;
    mode_next      = MODE_MENU;

    case (state_reg)
      ST_IDLE: begin
        if (left_edge) begin
          state_next     = ST_CLEAR;
          snake_clr_next = 1'b1;
          score_next     = '0;
          period_next    = PERIOD_INIT;
          cd_next        = CD_INIT;
          tick_next      = '0;
        end
      end

      ST_CLEAR: state_next = ST_COUNT;

      ST_COUNT: begin
        if (tick_expired) begin
          tick_next = '0;
          cd_next   = cd_reg - CD_W'(1);
          if (cd_reg == CD_W'(1)) begin
            state_next = ST_RUN;
          end
        end else begin
          tick_next = tick_reg + CNT_W'(1);
        end
      end

      // A pause request wins over a same-cycle expiry and freezes the count.
      ST_RUN: begin
        if (right_edge) begin
          state_next = ST_PAUSE;
        end else if (tick_expired) begin
          state_next     = ST_MOVE;
          tick_next      = '0;
          wait_next      = '0;
          move_step_next = 1'b1;
        end else begin
          tick_next = tick_reg + CNT_W'(1);
        end
      end

      // A done coinciding with our own request pulse is stale and not accepted.
      ST_MOVE: begin
        if (move_done && !move_step_reg) begin
          if (collision) begin
            state_next = ST_OVER;
          end else begin
            state_next    = ST_GEN;
            wait_next     = '0;
            gen_step_next = 1'b1;
          end
        end else if (wait_expired) begin
          state_next = ST_OVER;
        end else begin
          wait_next = wait_reg + WT_W'(1);
        end
      end

      ST_GEN: begin
        if (gen_done && !gen_step_reg) begin
          if (ate_point) begin
            if (score_reg != '1) begin
              score_next = score_reg + SCORE_W'(1);
            end
            if (32'(period_reg) < 32'(TICK_MIN + TICK_STEP)) begin
              period_next = PERIOD_MIN;
            end else begin
              period_next = period_reg - PERIOD_STEP;
            end
          end
          state_next = ST_RUN;
          tick_next  = '0;
        end else if (wait_expired) begin
          state_next = ST_OVER;
        end else begin
          wait_next = wait_reg + WT_W'(1);
        end
      end

      ST_PAUSE: begin
        if (right_edge) begin
          state_next = ST_RUN;
        end
      end

      ST_OVER: begin
        if (left_edge) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    case (state_next)
      ST_IDLE:  mode_next = MODE_MENU;
      ST_PAUSE: mode_next = MODE_PAUSE;
      ST_OVER:  mode_next = MODE_OVER;
      default:  mode_next = MODE_GAME;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      left_prev_reg  <= 1'b0;
      right_prev_reg <= 1'b0;
      tick_reg       <= '0;
      period_reg     <= PERIOD_INIT;
      cd_reg         <= '0;
      wait_reg       <= '0;
      score_reg      <= '0;
      move_step_reg  <= 1'b0;
      gen_step_reg   <= 1'b0;
      snake_clr_reg  <= 1'b0;
      mode_reg       <= MODE_MENU;
      countdown_reg  <= 2'd0;
    end else begin
      state_reg      <= state_next;
      left_prev_reg  <= left;
      right_prev_reg <= right;
      tick_reg       <= tick_next;
      period_reg     <= period_next;
      cd_reg         <= cd_next;
      wait_reg       <= wait_next;
      score_reg      <= score_next;
      move_step_reg  <= move_step_next;
      gen_step_reg   <= gen_step_next;
      snake_clr_reg  <= snake_clr_next;
      mode_reg       <= mode_next;
      countdown_reg  <= countdown_next;
    end
  end

  assign move_step = move_step_reg;
  assign gen_step  = gen_step_reg;
  assign snake_clr = snake_clr_reg;
  assign mode      = mode_reg;
  assign countdown = countdown_reg;
  assign score     = score_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes timed expected events, a monitor
// pops and compares every pulse or output change the DUT presents.
module tb_game_ctrl;

  logic       clk;
  logic       rst;
  logic       left, right;
  logic       move_done, collision, gen_done, ate_point;
  logic       move_step, gen_step, snake_clr;
  logic [1:0] mode, countdown;
  logic [1:0] score;

  game_ctrl #(
    .TICK_INIT(10), .TICK_MIN(4), .TICK_STEP(3),
    .COUNTDOWN_TICKS(2), .WAIT_TO(8), .SCORE_W(2)
  ) dut (
    .clk(clk), .rst(rst), .left(left), .right(right),
    .move_done(move_done), .collision(collision),
    .gen_done(gen_done), .ate_point(ate_point),
    .move_step(move_step), .gen_step(gen_step), .snake_clr(snake_clr),
    .mode(mode), .countdown(countdown), .score(score)
  );

  localparam int K_SNK = 0, K_MOVE = 1, K_GEN = 2, K_MODE = 3, K_CD = 4, K_SCORE = 5;

  typedef struct {
    int kind;
    int value;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_total = 0;
  int  n_pass = 0;
  bit  mon_en = 0;
  int  prev_mode = 0, prev_cd = 0, prev_score = 0;

  // Game 1: start, four eating steps (score saturates on the 4th), collision, back to menu.
  int g1_kind[19] = '{K_SNK, K_MODE, K_CD, K_CD, K_CD, K_MOVE, K_GEN, K_SCORE, K_MOVE, K_GEN,
                      K_SCORE, K_MOVE, K_GEN, K_SCORE, K_MOVE, K_GEN, K_MOVE, K_MODE, K_MODE};
  int g1_val[19]  = '{1, 1, 2, 1, 0, 1, 1, 1, 1, 1, 2, 1, 1, 3, 1, 1, 1, 3, 0};
  int g1_off[19]  = '{0, 0, 0, 11, 21, 31, 34, 37, 44, 47, 50, 54, 57, 60, 64, 67, 74, 77, 81};
  // Game 2: score cleared, pause at count 5 for 100 cycles, resume, move timeout.
  int g2_kind[10] = '{K_SNK, K_MODE, K_CD, K_SCORE, K_CD, K_CD, K_MODE, K_MODE, K_MOVE, K_MODE};
  int g2_val[10]  = '{1, 1, 2, 0, 1, 0, 2, 1, 1, 3};
  int g2_off[10]  = '{0, 0, 0, 0, 11, 21, 27, 128, 133, 141};

  // Per-step responder behaviour, indexed by move request number.
  int mv_dly_tab[8] = '{2, 2, 2, 2, 2, 10, 2, 2};
  int coll_tab[8]   = '{0, 0, 0, 0, 1, 0, 0, 0};
  int ate_tab[8]    = '{1, 1, 1, 1, 0, 0, 0, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int k);
    case (k)
      K_SNK:   return "snake_clr";
      K_MOVE:  return "move_step";
      K_GEN:   return "gen_step";
      K_MODE:  return "mode";
      K_CD:    return "countdown";
      default: return "score";
    endcase
  endfunction

  task automatic check_val(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) begin
      n_pass++;
      $display("cyc %0d: %s=%0d ok", cyc, name, act);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_event(input int kind, input int value);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got %s=%0d @%0d, expected no event",
               kind_name(kind), value, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.value == value && e.cyc == cyc) begin
        n_pass++;
        $display("cyc %0d: %s=%0d ok", cyc, kind_name(kind), value);
      end else begin
        $display("FAIL event: got %s=%0d @%0d, expected %s=%0d @%0d",
                 kind_name(kind), value, cyc, kind_name(e.kind), e.value, e.cyc);
      end
    end
  endtask

  task automatic push(input int kind, input int value, input int at);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every pulse and every change of a level output is one transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      if (snake_clr) check_event(K_SNK, 1);
      if (move_step) check_event(K_MOVE, 1);
      if (gen_step)  check_event(K_GEN, 1);
      if (int'(mode) != prev_mode)       check_event(K_MODE, int'(mode));
      if (int'(countdown) != prev_cd)    check_event(K_CD, int'(countdown));
      if (int'(score) != prev_score)     check_event(K_SCORE, int'(score));
      prev_mode  = int'(mode);
      prev_cd    = int'(countdown);
      prev_score = int'(score);
    end
  end

  // Move and point-generation responders.
  int   step_no = 0;
  int   mv_due = -1, gn_due = -1;
  logic mv_coll = 1'b0, gn_ate = 1'b0;
  initial begin
    move_done = 1'b0; collision = 1'b0; gen_done = 1'b0; ate_point = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      move_done = 1'b0; collision = 1'b0; gen_done = 1'b0; ate_point = 1'b0;
      if (rst && move_step && step_no < 8) begin
        mv_due  = cyc + mv_dly_tab[step_no];
        mv_coll = (coll_tab[step_no] != 0);
        gn_ate  = (ate_tab[step_no] != 0);
        step_no++;
      end
      if (rst && gen_step) gn_due = cyc + 2;
      if (cyc == mv_due) begin
        move_done = 1'b1;
        collision = mv_coll;
        mv_due    = -1;
      end
      if (cyc == gn_due) begin
        gen_done  = 1'b1;
        ate_point = gn_ate;
        gn_due    = -1;
      end
    end
  end

  int t0, s1, s2;
  initial begin
    rst = 1'b1; left = 1'b0; right = 1'b0;
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("reset_mode", int'(mode), 0);
    check_val("reset_score", int'(score), 0);
    check_val("reset_countdown", int'(countdown), 0);
    check_val("reset_move_step", int'(move_step), 0);
    check_val("reset_gen_step", int'(gen_step), 0);
    check_val("reset_snake_clr", int'(snake_clr), 0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    t0     = cyc;
    mon_en = 1'b1;

    // Quiet menu for 50 cycles, then start game 1.
    s1 = t0 + 51;
    for (int i = 0; i < 19; i++) push(g1_kind[i], g1_val[i], s1 + g1_off[i]);
    at_cycle(s1 - 1); left = 1'b1;
    at_cycle(s1);     left = 1'b0;
    at_cycle(s1 + 80); left = 1'b1;
    at_cycle(s1 + 81); left = 1'b0;

    // Game 2: pause/resume and move timeout.
    s2 = s1 + 91;
    for (int i = 0; i < 10; i++) push(g2_kind[i], g2_val[i], s2 + g2_off[i]);
    at_cycle(s2 - 1);   left = 1'b1;
    at_cycle(s2);       left = 1'b0;
    at_cycle(s2 + 26);  right = 1'b1;
    at_cycle(s2 + 27);  right = 1'b0;
    at_cycle(s2 + 127); right = 1'b1;
    at_cycle(s2 + 128); right = 1'b0;

    at_cycle(s2 + 170);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_total++;
      $display("FAIL missing_event: got nothing, expected %s=%0d @%0d",
               kind_name(e.kind), e.value, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
